// File: rtl/pixel_sink.sv
// pixel_sink: plot-interface responder with a small pixel FIFO feeding a framebuffer RAM.
// Also provides a full-screen clear sweep and a one-cycle-latency read-back port.
module pixel_sink #(
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int C_W        = 9,
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [X_W-1:0] x_in,
  input  logic [Y_W-1:0] y_in,
  input  logic [C_W-1:0] colour_in,
  input  logic           plot,
  output logic           ready,
  input  logic           hold,
  input  logic           clear,
  input  logic [C_W-1:0] clear_colour,
  output logic           busy,
  output logic           clear_done,
  input  logic [X_W-1:0] rd_x,
  input  logic [Y_W-1:0] rd_y,
  output logic [C_W-1:0] rd_colour,
  output logic [7:0]     oob_count,
  output logic           lost
);
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int A_W  = $clog2(NPIX);
  localparam int P_W  = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t         state_reg;
  logic [C_W-1:0] ram [0:NPIX-1];
  logic [A_W-1:0] fifo_addr [0:FIFO_DEPTH-1];
  logic [C_W-1:0] fifo_colour [0:FIFO_DEPTH-1];

  logic [P_W:0]   wr_ptr_reg, rd_ptr_reg, fifo_count;
  logic [A_W-1:0] sweep_reg;
  logic           clear_pending_reg, clear_done_reg, lost_reg, rd_oob_reg;
  logic [C_W-1:0] clear_colour_reg, rd_data_reg;
  logic [7:0]     oob_count_reg;

  logic           in_range, fifo_full, fifo_empty, accept, push, pop, ram_we, rd_in_range;
  logic [A_W-1:0] plot_addr, ram_waddr, rd_addr;
  logic [C_W-1:0] ram_wdata;
  logic [P_W-1:0] wr_idx, rd_idx;

  assign in_range   = (32'(x_in) < WIDTH) && (32'(y_in) < HEIGHT);
  assign plot_addr  = A_W'(32'(y_in) * WIDTH + 32'(x_in));
  assign fifo_count = wr_ptr_reg - rd_ptr_reg;
  assign fifo_full  = (fifo_count == (P_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign wr_idx     = wr_ptr_reg[P_W-1:0];
  assign rd_idx     = rd_ptr_reg[P_W-1:0];

  assign ready  = !fifo_full && !clear_pending_reg && (state_reg == IDLE);
  assign accept = plot && ready;
  assign push   = accept && in_range;
  // A pending clear will flush the FIFO, so draining it meanwhile is pointless.
  assign pop    = (state_reg == IDLE) && !clear_pending_reg && !fifo_empty && !hold;

  assign ram_we    = pop || ((state_reg == CLEAR) && !hold);
  assign ram_waddr = (state_reg == CLEAR) ? sweep_reg : fifo_addr[rd_idx];
  assign ram_wdata = (state_reg == CLEAR) ? clear_colour_reg : fifo_colour[rd_idx];

  assign rd_in_range = (32'(rd_x) < WIDTH) && (32'(rd_y) < HEIGHT);
  assign rd_addr     = rd_in_range ? A_W'(32'(rd_y) * WIDTH + 32'(rd_x)) : '0;

  assign busy       = !fifo_empty || clear_pending_reg || (state_reg == CLEAR);
  assign clear_done = clear_done_reg;
  assign oob_count  = oob_count_reg;
  assign lost       = lost_reg;
  assign rd_colour  = rd_oob_reg ? '0 : rd_data_reg;

  // RAM and FIFO storage carry no reset so they map onto memory primitives.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    rd_data_reg <= ram[rd_addr];
    if (push) begin
      fifo_addr[wr_idx]   <= plot_addr;
      fifo_colour[wr_idx] <= colour_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= IDLE;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      sweep_reg         <= '0;
      clear_pending_reg <= 1'b0;
      clear_colour_reg  <= '0;
      clear_done_reg    <= 1'b0;
      oob_count_reg     <= '0;
      lost_reg          <= 1'b0;
      rd_oob_reg        <= 1'b1;
    end else begin
      clear_done_reg <= 1'b0;
      rd_oob_reg     <= !rd_in_range;
      if (plot && !ready) lost_reg <= 1'b1;
      if (accept && !in_range && oob_count_reg != 8'hFF) oob_count_reg <= oob_count_reg + 8'd1;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case (state_reg)
        IDLE: begin
          if (clear_pending_reg) begin
            state_reg         <= CLEAR;
            sweep_reg         <= '0;
            clear_pending_reg <= 1'b0;
            rd_ptr_reg        <= wr_ptr_reg;
            if (clear) clear_colour_reg <= clear_colour;
          end else if (clear) begin
            clear_pending_reg <= 1'b1;
            clear_colour_reg  <= clear_colour;
          end
        end
        CLEAR: begin
          if (!hold) begin
            if (sweep_reg == A_W'(NPIX - 1)) begin
              state_reg      <= IDLE;
              clear_done_reg <= 1'b1;
            end else begin
              sweep_reg <= sweep_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_sink.sv
// Directed and randomized bench for pixel_sink with a queue-based FIFO/RAM reference model.
module tb_pixel_sink;
  localparam int WIDTH = 160, HEIGHT = 120, NPIX = WIDTH * HEIGHT, DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset, plot, hold, clear, ready, busy, clear_done, lost;
  logic [7:0] x_in, rd_x, oob_count;
  logic [6:0] y_in, rd_y;
  logic [8:0] colour_in, clear_colour, rd_colour;

  always #5 clk = ~clk;

  pixel_sink dut (
    .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .plot(plot), .ready(ready), .hold(hold), .clear(clear), .clear_colour(clear_colour),
    .busy(busy), .clear_done(clear_done), .rd_x(rd_x), .rd_y(rd_y),
    .rd_colour(rd_colour), .oob_count(oob_count), .lost(lost)
  );

  typedef struct {int addr; logic [8:0] c;} pix_t;
  pix_t       q[$];
  logic [8:0] mram [0:NPIX-1];
  int         oob_exp = 0;
  logic       lost_exp = 1'b0;
  int         total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock of the reference model: a FIFO of depth DEPTH draining one entry per unheld cycle.
  task automatic tick();
    bit rdy;
    rdy = (q.size() < DEPTH);
    chk("ready", ready, rdy);
    chk("busy", busy, q.size() != 0);
    if (!hold && q.size() > 0) begin
      pix_t p;
      p = q.pop_front();
      mram[p.addr] = p.c;
    end
    if (plot) begin
      if (!rdy) lost_exp = 1'b1;
      else if (int'(x_in) < WIDTH && int'(y_in) < HEIGHT)
        q.push_back('{addr: int'(y_in) * WIDTH + int'(x_in), c: colour_in});
      else if (oob_exp < 255) oob_exp++;
    end
    step();
  endtask

  task automatic rd(input int x, input int y, output logic [8:0] c);
    rd_x = 8'(x);
    rd_y = 7'(y);
    step();
    c = rd_colour;
  endtask

  task automatic chk_pix(input string tag, input int x, input int y);
    logic [8:0] c;
    rd(x, y, c);
    chk(tag, c, mram[y * WIDTH + x]);
  endtask

  // Issues a clear and counts edges after the request edge until clear_done is seen.
  task automatic run_clear(input logic [8:0] col, input int hold_at, input int hold_len, output int n);
    clear = 1'b1;
    clear_colour = col;
    step();
    clear = 1'b0;
    clear_colour = 9'($urandom);
    chk("clr_ready", ready, 0);
    chk("clr_busy", busy, 1);
    n = 0;
    for (int i = 0; i < 30000; i++) begin
      if (n == hold_at) hold = 1'b1;
      if (n == hold_at + hold_len) hold = 1'b0;
      step();
      n++;
      if (clear_done) break;
    end
    hold = 1'b0;
    chk("done_ready", ready, 1);
    chk("done_busy", busy, 0);
    step();
    chk("done_pulse", clear_done, 0);
    q.delete();
    for (int a = 0; a < NPIX; a++) mram[a] = col;
  endtask

  initial begin
    int n, k, a;
    logic [8:0] c;
    reset = 1'b1; plot = 1'b0; hold = 1'b0; clear = 1'b0;
    x_in = '0; y_in = '0; colour_in = '0; clear_colour = '0; rd_x = '0; rd_y = '0;
    step(); step();
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_rdcol", rd_colour, 0);
    chk("rst_oob", oob_count, 0);
    chk("rst_lost", lost, 0);
    reset = 1'b0;
    step();

    // Single plot, busy for exactly one cycle, read back
    x_in = 8'd3; y_in = 7'd5; colour_in = 9'h1FF; plot = 1'b1;
    tick();
    plot = 1'b0;
    tick(); tick();
    rd(3, 5, c);
    chk("t1_read", c, 9'h1FF);

    // Clear with four queued pixels
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x_in = 8'(20 + i * 7); y_in = 7'(30 + i); colour_in = 9'(i + 1); plot = 1'b1;
      tick();
    end
    plot = 1'b0;
    run_clear(9'h0A5, 0, 0, n);
    chk("t4_latency", n, 1 + NPIX);
    chk_pix("t4_first", 0, 0);
    chk_pix("t4_last", WIDTH - 1, HEIGHT - 1);
    for (int i = 0; i < 4; i++) chk_pix("t4_queued", 20 + i * 7, 30 + i);
    rd(WIDTH, 0, c);  chk("rd_oob_x", c, 0);
    rd(0, HEIGHT, c); chk("rd_oob_y", c, 0);

    // Fill under hold, overflow, then drain
    hold = 1'b1;
    for (int i = 0; i < 9; i++) begin
      x_in = 8'(40 + i); y_in = 7'd50; colour_in = 9'($urandom); plot = 1'b1;
      tick();
    end
    plot = 1'b0;
    chk("t2_lost", lost, 1);
    chk("t2_lost_model", lost, lost_exp);
    hold = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    for (int i = 0; i < 9; i++) chk_pix("t2_pix", 40 + i, 50);

    // Out-of-range plots and saturation
    plot = 1'b1; colour_in = 9'h111;
    x_in = 8'd160; y_in = 7'd0;   tick();
    x_in = 8'd0;   y_in = 7'd120; tick();
    x_in = 8'd200; y_in = 7'd119; tick();
    plot = 1'b0;
    tick();
    chk("t3_oob3", oob_count, 3);
    chk_pix("t3_unwritten", 0, 0);
    plot = 1'b1;
    for (int i = 0; i < 300; i++) begin
      x_in = 8'($urandom_range(160, 255)); y_in = 7'($urandom_range(0, 127));
      tick();
    end
    plot = 1'b0;
    tick();
    chk("t3_oob_sat", oob_count, 255);
    chk("t3_oob_model", oob_count, oob_exp);

    // Randomized plots with random hold over a small region
    for (int i = 0; i < 600; i++) begin
      plot = ($urandom_range(0, 3) != 0);
      hold = ($urandom_range(0, 2) == 0);
      x_in = 8'($urandom_range(0, 15)); y_in = 7'($urandom_range(0, 7));
      colour_in = 9'($urandom);
      tick();
    end
    plot = 1'b0; hold = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    tick();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) chk_pix("rand_pix", x, y);
    chk("rand_lost", lost, lost_exp);
    chk("rand_oob", oob_count, oob_exp);

    // Clear with a 100-cycle hold in the middle of the sweep
    run_clear(9'h13C, 1000, 100, n);
    chk("t5_latency", n, 1 + NPIX + 100);
    chk_pix("t5_first", 0, 0);
    chk_pix("t5_mid", 80, 60);
    chk_pix("t5_last", WIDTH - 1, HEIGHT - 1);

    // Reset in the middle of a sweep
    k = 500;
    clear = 1'b1; clear_colour = 9'h0F0;
    step();
    clear = 1'b0;
    repeat (k) step();
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_busy", busy, 0);
    step();
    chk("mid_rst_ready2", ready, 1);
    chk("mid_rst_busy2", busy, 0);
    chk("mid_rst_rdcol", rd_colour, 0);
    chk("mid_rst_oob", oob_count, 0);
    chk("mid_rst_lost", lost, 0);
    reset = 1'b0;
    oob_exp = 0; lost_exp = 1'b0;
    for (int i = 0; i <= k - 2; i++) mram[i] = 9'h0F0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (clear_done) n++;
    end
    chk("mid_rst_no_done", n, 0);
    a = k - 2;
    chk_pix("mid_rst_written", a % WIDTH, a / WIDTH);
    a = k - 1;
    chk_pix("mid_rst_unwritten", a % WIDTH, a / WIDTH);
    chk_pix("mid_rst_last", WIDTH - 1, HEIGHT - 1);
    rd(a % WIDTH, a / WIDTH, c);
    chk("mid_rst_old_colour", c, 9'h13C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
